// File: rtl/pacote_truco.sv
// pacote_truco: shared FSM states, score limits and hand-value raise sequence
package pacote_truco;

    typedef enum logic [1:0] {OCIOSO, APURA, SOMA, FIM} estado_t;

    localparam logic [3:0] PONTOS_VITORIA = 4'd12;
    localparam logic [3:0] VALOR_MAX      = 4'd12;

    localparam logic [3:0] VALOR_1 = 4'd1;
    localparam logic [3:0] VALOR_3 = 4'd3;
    localparam logic [3:0] VALOR_6 = 4'd6;
    localparam logic [3:0] VALOR_9 = 4'd9;

    localparam logic [1:0] VENC_NENHUM = 2'b00;
    localparam logic [1:0] VENC_J1     = 2'b01;
    localparam logic [1:0] VENC_J2     = 2'b10;

    // Next hand value after an accepted truco; the top value is sticky.
    function automatic logic [3:0] proximo_valor(input logic [3:0] v);
        return v == VALOR_1 ? VALOR_3 :
               v == VALOR_3 ? VALOR_6 :
               v == VALOR_6 ? VALOR_9 : VALOR_MAX;
    endfunction

endpackage

// File: rtl/apura_mao.sv
// apura_mao: combinational decision of which player won a three-round hand
module apura_mao
    import pacote_truco::*;
(
    input  logic [2:0] placar1_i,
    input  logic [2:0] placar2_i,
    output logic [1:0] vencedor_o
);

    logic [2:0] g1, g2;
    logic [1:0] n1, n2;

    // Rounds claimed by both players are draws; count the rest, then fall back to the earliest decided round.
    always_comb begin
        g1 = placar1_i & ~placar2_i;
        g2 = placar2_i & ~placar1_i;
        n1 = 2'(g1[0]) + 2'(g1[1]) + 2'(g1[2]);
        n2 = 2'(g2[0]) + 2'(g2[1]) + 2'(g2[2]);
        vencedor_o = n1 > n2 ? VENC_J1 :
                     n2 > n1 ? VENC_J2 :
                     g1[0]   ? VENC_J1 :
                     g2[0]   ? VENC_J2 :
                     g1[1]   ? VENC_J1 :
                     g2[1]   ? VENC_J2 :
                     g1[2]   ? VENC_J1 :
                     g2[2]   ? VENC_J2 : VENC_NENHUM;
    end

endmodule

// File: rtl/contador_pontos.sv
// contador_pontos: truco game score keeper with hand-value raises and game-over detection
module contador_pontos #(
    parameter logic [3:0] PONTOS_VITORIA = pacote_truco::PONTOS_VITORIA
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       valido,
    input  logic [2:0] placar1,
    input  logic [2:0] placar2,
    input  logic       truco,
    input  logic       novo_jogo,
    output logic [3:0] pontos1,
    output logic [3:0] pontos2,
    output logic [3:0] valor_mao,
    output logic       mao_ok,
    output logic       fim_jogo,
    output logic [1:0] vencedor
);

    import pacote_truco::*;

    estado_t    estado_q;
    logic [2:0] p1_q, p2_q;
    logic [1:0] venc_mao_q, venc_mao_d;
    logic [3:0] pontos1_q, pontos2_q, valor_q;
    logic       mao_ok_q, fim_q;
    logic [1:0] vencedor_q;
    logic [4:0] soma1_d, soma2_d;
    logic [3:0] pontos1_d, pontos2_d;

    apura_mao u_apura (
        .placar1_i (p1_q),
        .placar2_i (p2_q),
        .vencedor_o(venc_mao_d)
    );

    // Candidate scores after crediting the hand, saturated at the winning score.
    always_comb begin
        soma1_d   = {1'b0, pontos1_q} + {1'b0, valor_q};
        soma2_d   = {1'b0, pontos2_q} + {1'b0, valor_q};
        pontos1_d = venc_mao_q != VENC_J1 ? pontos1_q :
                    soma1_d >= {1'b0, PONTOS_VITORIA} ? PONTOS_VITORIA : soma1_d[3:0];
        pontos2_d = venc_mao_q != VENC_J2 ? pontos2_q :
                    soma2_d >= {1'b0, PONTOS_VITORIA} ? PONTOS_VITORIA : soma2_d[3:0];
    end

    // Game FSM: capture a hand, decide its winner, credit points, stop at game over.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            estado_q   <= OCIOSO;
            p1_q       <= 3'b000;
            p2_q       <= 3'b000;
            venc_mao_q <= VENC_NENHUM;
            pontos1_q  <= 4'd0;
            pontos2_q  <= 4'd0;
            valor_q    <= VALOR_1;
            mao_ok_q   <= 1'b0;
            fim_q      <= 1'b0;
            vencedor_q <= VENC_NENHUM;
        end else begin
            mao_ok_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (truco) valor_q <= proximo_valor(valor_q);
                    if (valido) begin
                        p1_q     <= placar1;
                        p2_q     <= placar2;
                        estado_q <= APURA;
                    end
                end
                APURA: begin
                    venc_mao_q <= venc_mao_d;
                    estado_q   <= SOMA;
                end
                SOMA: begin
                    pontos1_q  <= pontos1_d;
                    pontos2_q  <= pontos2_d;
                    mao_ok_q   <= 1'b1;
                    valor_q    <= VALOR_1;
                    fim_q      <= pontos1_d == PONTOS_VITORIA || pontos2_d == PONTOS_VITORIA;
                    vencedor_q <= pontos1_d == PONTOS_VITORIA ? VENC_J1 :
                                  pontos2_d == PONTOS_VITORIA ? VENC_J2 : VENC_NENHUM;
                    estado_q   <= pontos1_d == PONTOS_VITORIA || pontos2_d == PONTOS_VITORIA ? FIM : OCIOSO;
                end
                FIM: begin
                    if (novo_jogo) begin
                        pontos1_q  <= 4'd0;
                        pontos2_q  <= 4'd0;
                        valor_q    <= VALOR_1;
                        vencedor_q <= VENC_NENHUM;
                        fim_q      <= 1'b0;
                        estado_q   <= OCIOSO;
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign pontos1   = pontos1_q;
    assign pontos2   = pontos2_q;
    assign valor_mao = valor_q;
    assign mao_ok    = mao_ok_q;
    assign fim_jogo  = fim_q;
    assign vencedor  = vencedor_q;

endmodule

// File: tb/tb_contador_pontos.sv
// tb_contador_pontos: directed scoreboard bench for the truco score keeper
module tb_contador_pontos;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       valido = 1'b0;
    logic [2:0] placar1 = 3'b000;
    logic [2:0] placar2 = 3'b000;
    logic       truco = 1'b0;
    logic       novo_jogo = 1'b0;
    logic [3:0] pontos1, pontos2, valor_mao;
    logic       mao_ok, fim_jogo;
    logic [1:0] vencedor;

    typedef struct {
        int p1;
        int p2;
        int fim;
        int venc;
    } esperado_t;

    esperado_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    int exp_p1 = 0;
    int exp_p2 = 0;
    int exp_valor = 1;

    contador_pontos dut (
        .clk      (clk),
        .clr      (clr),
        .valido   (valido),
        .placar1  (placar1),
        .placar2  (placar2),
        .truco    (truco),
        .novo_jogo(novo_jogo),
        .pontos1  (pontos1),
        .pontos2  (pontos2),
        .valor_mao(valor_mao),
        .mao_ok   (mao_ok),
        .fim_jogo (fim_jogo),
        .vencedor (vencedor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int subir(input int v);
        case (v)
            1: return 3;
            3: return 6;
            6: return 9;
            default: return 12;
        endcase
    endfunction

    // Reference hand decision: 1 = player 1, 2 = player 2, 0 = void.
    function automatic int ganhador(input logic [2:0] a, input logic [2:0] b);
        int w1 = 0;
        int w2 = 0;
        int primeiro = 0;
        for (int i = 0; i < 3; i++) begin
            if (a[i] !== b[i]) begin
                if (a[i]) w1++;
                else w2++;
                if (primeiro == 0) primeiro = a[i] ? 1 : 2;
            end
        end
        return w1 > w2 ? 1 : w2 > w1 ? 2 : primeiro;
    endfunction

    task automatic mao(input logic [2:0] a, input logic [2:0] b, input int nt, input bit junto);
        esperado_t e;
        esperado_t r;
        int w;
        int lat;
        for (int t = 0; t < nt; t++) begin
            truco = 1'b1;
            @(negedge clk);
            truco = 1'b0;
            exp_valor = subir(exp_valor);
            chk("valor_truco", valor_mao, exp_valor);
        end
        placar1 = a;
        placar2 = b;
        valido = 1'b1;
        truco = junto;
        if (junto) exp_valor = subir(exp_valor);
        w = ganhador(a, b);
        if (w == 1) exp_p1 = exp_p1 + exp_valor > 12 ? 12 : exp_p1 + exp_valor;
        if (w == 2) exp_p2 = exp_p2 + exp_valor > 12 ? 12 : exp_p2 + exp_valor;
        e.p1 = exp_p1;
        e.p2 = exp_p2;
        e.fim = (exp_p1 == 12 || exp_p2 == 12) ? 1 : 0;
        e.venc = exp_p1 == 12 ? 1 : exp_p2 == 12 ? 2 : 0;
        sb.push_back(e);
        @(negedge clk);
        valido = 1'b0;
        truco = 1'b0;
        lat = 1;
        while (!mao_ok && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        chk("mao_ok_seen", mao_ok, 1);
        chk("latency", lat, 3);
        if (mao_ok && sb.size() > 0) begin
            r = sb.pop_front();
            chk("pontos1", pontos1, r.p1);
            chk("pontos2", pontos2, r.p2);
            chk("fim_jogo", fim_jogo, r.fim);
            chk("vencedor", vencedor, r.venc);
        end
        exp_valor = 1;
        chk("valor_reset", valor_mao, 1);
        @(negedge clk);
        chk("mao_ok_pulse", mao_ok, 0);
    endtask

    initial begin
        int pulsos;
        repeat (2) @(negedge clk);
        chk("rst_pontos1", pontos1, 0);
        chk("rst_pontos2", pontos2, 0);
        chk("rst_valor", valor_mao, 1);
        chk("rst_mao_ok", mao_ok, 0);
        chk("rst_fim", fim_jogo, 0);
        chk("rst_vencedor", vencedor, 0);
        clr = 1'b1;
        @(negedge clk);
        mao(3'b011, 3'b100, 0, 0);
        mao(3'b001, 3'b110, 3, 0);
        mao(3'b000, 3'b000, 5, 0);
        mao(3'b011, 3'b010, 0, 0);
        novo_jogo = 1'b1;
        @(negedge clk);
        novo_jogo = 1'b0;
        @(negedge clk);
        chk("novo_ign_p1", pontos1, exp_p1);
        chk("novo_ign_p2", pontos2, exp_p2);
        chk("novo_ign_fim", fim_jogo, 0);
        mao(3'b001, 3'b100, 2, 0);
        mao(3'b101, 3'b010, 0, 0);
        mao(3'b110, 3'b001, 0, 0);
        mao(3'b010, 3'b001, 0, 0);
        mao(3'b011, 3'b000, 0, 1);
        placar1 = 3'b111;
        placar2 = 3'b000;
        valido = 1'b1;
        truco = 1'b1;
        @(negedge clk);
        valido = 1'b0;
        truco = 1'b0;
        pulsos = 0;
        repeat (5) begin
            @(negedge clk);
            if (mao_ok) pulsos++;
        end
        chk("fim_no_mao_ok", pulsos, 0);
        chk("fim_hold_p1", pontos1, exp_p1);
        chk("fim_hold_p2", pontos2, exp_p2);
        chk("fim_hold_fim", fim_jogo, 1);
        chk("fim_hold_venc", vencedor, 1);
        chk("fim_hold_valor", valor_mao, 1);
        novo_jogo = 1'b1;
        @(negedge clk);
        novo_jogo = 1'b0;
        exp_p1 = 0;
        exp_p2 = 0;
        chk("novo_p1", pontos1, 0);
        chk("novo_p2", pontos2, 0);
        chk("novo_valor", valor_mao, 1);
        chk("novo_fim", fim_jogo, 0);
        chk("novo_venc", vencedor, 0);
        mao(3'b100, 3'b000, 0, 0);
        truco = 1'b1;
        @(negedge clk);
        truco = 1'b0;
        placar1 = 3'b110;
        placar2 = 3'b000;
        valido = 1'b1;
        @(negedge clk);
        valido = 1'b0;
        clr = 1'b0;
        exp_p1 = 0;
        exp_p2 = 0;
        exp_valor = 1;
        #1;
        chk("async_p1", pontos1, 0);
        chk("async_valor", valor_mao, 1);
        @(negedge clk);
        clr = 1'b1;
        pulsos = 0;
        repeat (4) begin
            @(negedge clk);
            if (mao_ok) pulsos++;
        end
        chk("clr_no_mao_ok", pulsos, 0);
        chk("clr_p1", pontos1, 0);
        chk("clr_p2", pontos2, 0);
        chk("clr_valor", valor_mao, 1);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/contador_pontos.md
CONTADOR_PONTOS -- requirements
Module: contador_pontos

Interface
REQ-001 The block SHALL have one clock domain and an asynchronous, active-low reset.
REQ-002 PONTOS_VITORIA, default 12, game-winning score.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 clr  in  1  asynchronous active-low reset.
REQ-005 valido  in  1  one-cycle pulse; placar1/placar2 hold a finished hand.
REQ-006 placar1  in  3  bit i = player 1 won round i of the hand.
REQ-007 placar2  in  3  bit i = player 2 won round i of the hand.
REQ-008 truco  in  1  one-cycle pulse; accepted raise of the hand value.
REQ-009 novo_jogo  in  1  synchronous restart request, honoured only in FIM.
REQ-010 pontos1, pontos2  out  4  game score per player, 0..12.
REQ-011 valor_mao  out  4  current hand value, one of 1,3,6,9,12.
REQ-012 mao_ok  out  1  one-cycle pulse; a hand was scored.
REQ-013 fim_jogo  out  1  high while in FIM.
REQ-014 vencedor  out  2  00 none, 01 player 1, 10 player 2; valid while fim_jogo.

Function
REQ-015 The FSM SHALL have states OCIOSO, APURA, SOMA and FIM.
REQ-016 OCIOSO: on valido, capture placar1/placar2 into registers and go to APURA next cycle.
REQ-017 OCIOSO: on truco, step valor_mao 1->3->6->9->12; at 12, hold 12.
REQ-018 If valido and truco arrive in the same cycle, the raise SHALL apply first; the hand is scored at the raised value.
REQ-019 valido and truco SHALL be ignored in APURA, SOMA and FIM.
REQ-020 APURA: a round whose bit is set for both players SHALL count as drawn for both.
REQ-021 APURA: the player who won more non-drawn rounds wins the hand.
REQ-022 APURA, equal counts: the winner of the lowest-index non-drawn round wins the hand; if all rounds are drawn or empty, the hand is void.
REQ-023 SOMA: add valor_mao to the hand winner's score, saturating at PONTOS_VITORIA.
REQ-024 SOMA: pulse mao_ok for one cycle, reset valor_mao to 1, and update pontos at the clock edge ending SOMA.
REQ-025 Latency: valido at edge N -> pontos updated and mao_ok high in the cycle after edge N+2.
REQ-026 A void hand SHALL still pulse mao_ok and reset valor_mao, but leave scores unchanged.
REQ-027 After SOMA, a score equal to PONTOS_VITORIA -> FIM, with vencedor set to that player; otherwise -> OCIOSO.
REQ-028 FIM: scores and vencedor SHALL hold; novo_jogo clears scores, sets valor_mao=1 and vencedor=00, then -> OCIOSO.
REQ-029 novo_jogo outside FIM SHALL be ignored.

Reset
REQ-030 clr low SHALL force, asynchronously, state=OCIOSO, pontos1=pontos2=0, valor_mao=1, mao_ok=0, fim_jogo=0, vencedor=00, and the captured placares to 0.
REQ-031 Reset during APURA or SOMA SHALL discard the hand in progress without a mao_ok pulse.

Structure
REQ-032 Package pacote_truco SHALL hold the FSM state enum, PONTOS_VITORIA, VALOR_MAX=12, and the raise sequence constants.
REQ-033 Hand-winner decoding (REQ-020..022) SHALL be a combinational sub-module apura_mao: two 3-bit inputs, 2-bit winner output.

Verification
REQ-034 Reset, then valido with placar1=011, placar2=100 -> mao_ok two cycles later, pontos1=1, pontos2=0, valor_mao=1.
REQ-035 Three truco pulses, then valido with placar1=001, placar2=110 -> pontos2 +=9; a fourth and fifth truco before valido -> value 12, held at 12.
REQ-036 placar1=011, placar2=010 (round 1 drawn, player 1 wins round 0) -> player 1 +1; placar1=000, placar2=000 -> void hand, mao_ok pulses, scores unchanged.
REQ-037 pontos1=10, truco then valido with player 1 winning -> pontos1=12 (saturated from 13), fim_jogo=1, vencedor=01; further valido is ignored; novo_jogo -> all cleared, OCIOSO.
REQ-038 clr asserted the cycle after valido -> scores stay 0, no mao_ok pulse, valor_mao=1 after release.
